ip_input_cond: RTL and testbench

IP_INPUT_COND -- requirements
Module: ip_input_cond

---
 rtl/ip_pkg.sv | 15 +
 rtl/ip_debounce_bit.sv | 53 +++++
 rtl/ip_input_cond.sv | 54 +++++
 tb/tb_ip_input_cond.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ip_pkg.sv
// Shared constants for the input-conditioning block.
// Provides channel widths, default debounce length and counter sizing.
package ip_pkg;

    localparam int IO_SW_W           = 32;
    localparam int IO_BTN_W          = 4;
    localparam int IO_CH_W           = IO_SW_W + IO_BTN_W;
    localparam int DB_CYCLES_DEFAULT = 16;

    // Counter width able to hold 0..db_cycles.
    function automatic int db_cnt_w(input int db_cycles);
        return $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/ip_debounce_bit.sv
// Single-channel 2-flop synchronizer plus stability counter.
// Ports: i_clk, i_rst (sync, active-high), i_raw (async pin), o_q (stable level).
module ip_debounce_bit
    import ip_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_q
);

    localparam int             CW       = db_cnt_w(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          lvl_q;
    logic          lvl_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          s;

    assign s = sync_q[1];

    // Any cycle where s matches the held level restarts the count.
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (s != lvl_q) begin
            if (cnt_q == CNT_LAST) begin
                lvl_d = s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
            lvl_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], i_raw};
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_q = lvl_q;

endmodule

// File: rtl/ip_input_cond.sv
// Debounces 32 switches and 4 buttons; emits press and switch-change pulses.
// Ports: i_clk, i_rst, i_sw_raw, i_btn_raw -> o_io_sw, o_io_btn, o_btn_press, o_sw_chg.
module ip_input_cond
    import ip_pkg::*;
#(
    parameter int DB_CYCLES      = DB_CYCLES_DEFAULT,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [IO_SW_W-1:0]  i_sw_raw,
    input  logic [IO_BTN_W-1:0] i_btn_raw,
    output logic [IO_SW_W-1:0]  o_io_sw,
    output logic [IO_BTN_W-1:0] o_io_btn,
    output logic [IO_BTN_W-1:0] o_btn_press,
    output logic                o_sw_chg
);

    logic [IO_BTN_W-1:0] btn_cond;
    logic [IO_CH_W-1:0]  raw_ch;
    logic [IO_CH_W-1:0]  lvl;
    logic [IO_CH_W-1:0]  lvl_prev_q;

    // Normalise buttons so 1 always means pressed.
    assign btn_cond = BTN_ACTIVE_LOW ? ~i_btn_raw : i_btn_raw;
    assign raw_ch   = {btn_cond, i_sw_raw};

    for (genvar g = 0; g < IO_CH_W; g++) begin : g_ch
        ip_debounce_bit #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .i_clk(i_clk),
            .i_rst(i_rst),
            .i_raw(raw_ch[g]),
            .o_q  (lvl[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lvl_prev_q <= '0;
        end else begin
            lvl_prev_q <= lvl;
        end
    end

    assign o_io_sw  = lvl[IO_SW_W-1:0];
    assign o_io_btn = lvl[IO_CH_W-1:IO_SW_W];

    // Edges are taken between registered levels, so pulses stay glitch-free.
    assign o_btn_press = o_io_btn & ~lvl_prev_q[IO_CH_W-1:IO_SW_W];
    assign o_sw_chg    = |(o_io_sw ^ lvl_prev_q[IO_SW_W-1:0]);

endmodule

// File: tb/tb_ip_input_cond.sv
// Directed bench for ip_input_cond with a sliding-window reference model.
// DB_CYCLES=4, active-low buttons.
module tb_ip_input_cond;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sw_raw = '0;
    logic [3:0]  btn_raw = 4'hF;
    logic [31:0] io_sw;
    logic [3:0]  io_btn;
    logic [3:0]  btn_press;
    logic        sw_chg;

    int total = 0;
    int bad   = 0;

    ip_input_cond #(
        .DB_CYCLES(DB),
        .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_sw_raw   (sw_raw),
        .i_btn_raw  (btn_raw),
        .o_io_sw    (io_sw),
        .o_io_btn   (io_btn),
        .o_btn_press(btn_press),
        .o_sw_chg   (sw_chg)
    );

    always #5 clk = ~clk;

    // Model: smp[0] is the raw value taken at the previous edge (first sync
    // flop); smp[1..DB] are the synchronized values seen at the last DB edges.
    // A channel flips when all of those DB values disagree with its level.
    logic [35:0] smp [0:DB];
    logic [35:0] mq      = '0;
    logic [35:0] mq_prev = '0;
    bit          mvalid  = 1'b0;

    always @(posedge clk) begin
        logic [35:0] flip;
        if (rst) begin
            for (int j = 0; j <= DB; j++) smp[j] <= '0;
            mq      <= '0;
            mq_prev <= '0;
            mvalid  <= 1'b1;
        end else begin
            flip = '1;
            for (int j = 1; j <= DB; j++) flip &= smp[j] ^ mq;
            mq_prev <= mq;
            mq      <= mq ^ flip;
            smp[0]  <= {~btn_raw, sw_raw};
            for (int j = 1; j <= DB; j++) smp[j] <= smp[j-1];
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [3:0] exp_press;
        logic       exp_chg;
        if (mvalid) begin
            exp_press = mq[35:32] & ~mq_prev[35:32];
            exp_chg   = (mq[31:0] != mq_prev[31:0]);
            total += 4;
            if (io_sw !== mq[31:0]) begin
                bad++;
                $display("FAIL model_sw t=%0t got=%h exp=%h", $time, io_sw, mq[31:0]);
            end
            if (io_btn !== mq[35:32]) begin
                bad++;
                $display("FAIL model_btn t=%0t got=%h exp=%h", $time, io_btn, mq[35:32]);
            end
            if (btn_press !== exp_press) begin
                bad++;
                $display("FAIL model_press t=%0t got=%h exp=%h", $time, btn_press, exp_press);
            end
            if (sw_chg !== exp_chg) begin
                bad++;
                $display("FAIL model_chg t=%0t got=%b exp=%b", $time, sw_chg, exp_chg);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int pulses;

        // Reset with buttons released (active-low) and switches low.
        step(3);
        chk("rst_sw", io_sw, 32'h0);
        chk("rst_btn", {28'h0, io_btn}, 32'h0);
        chk("rst_press", {28'h0, btn_press}, 32'h0);
        chk("rst_chg", {31'h0, sw_chg}, 32'h0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (io_sw != 0 || io_btn != 0 || btn_press != 0 || sw_chg) pulses++;
        end
        chk("idle_quiet", pulses, 0);

        // Press button 0: visible on the 6th edge, one press pulse.
        btn_raw = 4'hE;
        step(5);
        chk("b0_pre", {28'h0, io_btn}, 32'h0);
        step(1);
        chk("b0_on", {28'h0, io_btn}, 32'h1);
        chk("b0_press", {28'h0, btn_press}, 32'h1);
        step(1);
        chk("b0_press_end", {28'h0, btn_press}, 32'h0);
        step(3);
        btn_raw = 4'hF;
        step(5);
        chk("b0_rel_pre", {28'h0, io_btn}, 32'h1);
        step(1);
        chk("b0_off", {28'h0, io_btn}, 32'h0);
        chk("b0_no_press", {28'h0, btn_press}, 32'h0);

        // Short switch glitch is filtered.
        sw_raw = 32'h20;
        step(3);
        sw_raw = 32'h0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (io_sw != 0 || sw_chg) pulses++;
        end
        chk("glitch", pulses, 0);

        // Many switch bits at once: one change pulse.
        sw_raw = 32'hA5A5_0F0F;
        step(5);
        chk("sw_pre", io_sw, 32'h0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (sw_chg) pulses++;
            if (i == 0) chk("sw_on", io_sw, 32'hA5A5_0F0F);
        end
        chk("sw_one_pulse", pulses, 1);

        // Toggle back before acceptance restarts the full count.
        sw_raw = 32'hA5A5_0F1F;
        step(3);
        sw_raw = 32'hA5A5_0F0F;
        step(1);
        sw_raw = 32'hA5A5_0F1F;
        step(5);
        chk("restart_pre", io_sw, 32'hA5A5_0F0F);
        step(1);
        chk("restart_on", io_sw, 32'hA5A5_0F1F);
        step(3);

        // Button 1 held; reset hits on the third count cycle.
        btn_raw = 4'hD;
        step(4);
        chk("b1_mid", {28'h0, io_btn}, 32'h0);
        rst = 1'b1;
        step(1);
        chk("b1_rst", {28'h0, io_btn}, 32'h0);
        chk("b1_rst_sw", io_sw, 32'h0);
        rst = 1'b0;
        step(5);
        chk("b1_pre", {28'h0, io_btn}, 32'h0);
        step(1);
        chk("b1_on", {28'h0, io_btn}, 32'h2);
        chk("b1_press", {28'h0, btn_press}, 32'h2);
        chk("b1_sw_back", io_sw, 32'hA5A5_0F1F);
        step(1);
        chk("b1_press_end", {28'h0, btn_press}, 32'h0);
        step(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
